// File: rtl/datareq_pkg.sv
// Shared definitions for the datareq stage: RV32I load/store opcodes, funct3
// codes, instruction field positions and the access-size decode helper.
package datareq_pkg;

    localparam int XLEN = 32;

    // Major opcodes of the two memory instruction classes.
    localparam logic [6:0] BOP_LOAD  = 7'b0000011;
    localparam logic [6:0] BOP_STORE = 7'b0100011;

    // Load funct3 codes.
    localparam logic [2:0] FUNCT3_LB  = 3'd0;
    localparam logic [2:0] FUNCT3_LH  = 3'd1;
    localparam logic [2:0] FUNCT3_LW  = 3'd2;
    localparam logic [2:0] FUNCT3_LBU = 3'd4;
    localparam logic [2:0] FUNCT3_LHU = 3'd5;

    // Store funct3 codes.
    localparam logic [2:0] FUNCT3_SB = 3'd0;
    localparam logic [2:0] FUNCT3_SH = 3'd1;
    localparam logic [2:0] FUNCT3_SW = 3'd2;

    // Instruction field ranges.
    localparam int INST_OPCODE_LSB = 0;
    localparam int INST_OPCODE_MSB = 6;
    localparam int INST_FUNCT3_LSB = 12;
    localparam int INST_FUNCT3_MSB = 14;

    // Access width of a memop; SZ_NONE marks an illegal funct3.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_NONE = 2'd3
    } acc_size_e;

    // Maps funct3 to an access width; stores have no unsigned variants.
    function automatic acc_size_e decode_size(input logic [2:0] funct3,
                                              input logic       is_store);
        acc_size_e sz;
        sz = SZ_NONE;
        if (is_store) begin
            case (funct3)
                FUNCT3_SB: sz = SZ_BYTE;
                FUNCT3_SH: sz = SZ_HALF;
                FUNCT3_SW: sz = SZ_WORD;
                default:   sz = SZ_NONE;
            endcase
        end else begin
            case (funct3)
                FUNCT3_LB, FUNCT3_LBU: sz = SZ_BYTE;
                FUNCT3_LH, FUNCT3_LHU: sz = SZ_HALF;
                FUNCT3_LW:             sz = SZ_WORD;
                default:               sz = SZ_NONE;
            endcase
        end
        return sz;
    endfunction

endpackage

// File: rtl/datareq_dmem_fmt.sv
// Combinational memop formatter: byte enables, lane-replicated store data and
// the misaligned / illegal-funct3 flag for one load or store.
module dmem_fmt
    import datareq_pkg::*;
(
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      addr_i,
    input  logic            is_store_i,
    input  logic [XLEN-1:0] r1data_i,
    output logic [3:0]      be_o,
    output logic [XLEN-1:0] wdata_o,
    output logic            maerr_o
);

    acc_size_e size;

    assign size = decode_size(funct3_i, is_store_i);

    // Byte-lane placement and alignment check for the decoded access width.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        be_o    = 4'b0000;
        wdata_o = '0;
        maerr_o = 1'b0;
        case (size)
            SZ_BYTE: begin
                be_o    = 4'b0001 << addr_i;
                wdata_o = {4{r1data_i[7:0]}};
            end
            SZ_HALF: begin
                be_o    = 4'b0011 << {addr_i[1], 1'b0};
                wdata_o = {2{r1data_i[15:0]}};
                maerr_o = addr_i[0];
            end
            SZ_WORD: begin
                be_o    = 4'b1111;
                wdata_o = r1data_i;
                maerr_o = |addr_i;
            end
            default: maerr_o = 1'b1;
        endcase
        // Loads carry no write data.
        if (!is_store_i) begin
            wdata_o = '0;
        end
    end

endmodule

// File: rtl/datareq.sv
// datareq: one-entry pipeline stage ahead of datam. Captures the execute
// bundle, issues the data-memory request for legal aligned memops and hands
// the bundle downstream with valid/ready flow control.
module datareq
    import datareq_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    output logic            ready_o,
    output logic            valid_ro,
    input  logic            ready_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] inst_i,
    input  logic [XLEN-1:0] r0data_i,
    input  logic [XLEN-1:0] r1data_i,
    input  logic [XLEN-1:0] result_i,
    output logic [XLEN-1:0] pc_ro,
    output logic [XLEN-1:0] inst_ro,
    output logic [XLEN-1:0] r0data_ro,
    output logic [XLEN-1:0] r1data_ro,
    output logic [XLEN-1:0] result_ro,
    output logic            maerr_ro,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [3:0]      dmem_be_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_gnt_i
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_REQ   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e          state_q;
    logic            valid_q, maerr_q, we_q;
    logic [XLEN-1:0] pc_q, inst_q, r0data_q, r1data_q, result_q;
    logic [XLEN-1:0] addr_q, wdata_q;
    logic [3:0]      be_q;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            is_load, is_store, is_memop;
    logic [3:0]      fmt_be;
    logic [XLEN-1:0] fmt_wdata;
    logic            fmt_maerr;
    logic            issue_d;
    logic            accept;

    assign opcode   = inst_i[INST_OPCODE_MSB:INST_OPCODE_LSB];
    assign funct3   = inst_i[INST_FUNCT3_MSB:INST_FUNCT3_LSB];
    assign is_load  = (opcode == BOP_LOAD);
    assign is_store = (opcode == BOP_STORE);
    assign is_memop = is_load | is_store;

    dmem_fmt u_fmt (
        .funct3_i   (funct3),
        .addr_i     (result_i[1:0]),
        .is_store_i (is_store),
        .r1data_i   (r1data_i),
        .be_o       (fmt_be),
        .wdata_o    (fmt_wdata),
        .maerr_o    (fmt_maerr)
    );

    // A captured bundle goes to REQ only when it is a legal, aligned memop.
    assign issue_d = is_memop & ~fmt_maerr;

    // Acceptance depends on state and downstream ready only, never on valid_i.
    assign ready_o    = (state_q == ST_EMPTY) | ((state_q == ST_FULL) & ready_i);
    assign accept     = valid_i & ready_o;
    assign dmem_req_o = (state_q == ST_REQ);

    // Stage FSM: capture on accept, wait for grant in REQ, drain in FULL.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every register, including the data bundle, is cleared on reset so outputs read zero.
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            valid_q  <= 1'b0;
            maerr_q  <= 1'b0;
            we_q     <= 1'b0;
            pc_q     <= '0;
            inst_q   <= '0;
            r0data_q <= '0;
            r1data_q <= '0;
            result_q <= '0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state_q)
                ST_EMPTY, ST_FULL: begin
                    if (accept) begin
                        pc_q     <= pc_i;
                        inst_q   <= inst_i;
                        r0data_q <= r0data_i;
                        r1data_q <= r1data_i;
                        result_q <= result_i;
                        maerr_q  <= is_memop & fmt_maerr;
                        we_q     <= issue_d & is_store;
                        addr_q   <= issue_d ? {result_i[XLEN-1:2], 2'b00} : '0;
                        be_q     <= issue_d ? fmt_be : 4'b0000;
                        wdata_q  <= issue_d ? fmt_wdata : '0;
                        valid_q  <= ~issue_d;
                        state_q  <= issue_d ? ST_REQ : ST_FULL;
                    end else if ((state_q == ST_FULL) && ready_i) begin
                        valid_q <= 1'b0;
                        state_q <= ST_EMPTY;
                    end
                end
                ST_REQ: begin
                    // Grant wins over ready_i: the bundle is only now complete.
                    if (dmem_gnt_i) begin
                        valid_q <= 1'b1;
                        state_q <= ST_FULL;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= ST_EMPTY;
                end
            endcase
        end
    end

    assign valid_ro     = valid_q;
    assign maerr_ro     = maerr_q;
    assign pc_ro        = pc_q;
    assign inst_ro      = inst_q;
    assign r0data_ro    = r0data_q;
    assign r1data_ro    = r1data_q;
    assign result_ro    = result_q;
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_be_o    = be_q;
    assign dmem_wdata_o = wdata_q;

endmodule

// File: tb/tb_datareq.sv
// Self-checking bench for datareq: directed scenarios plus a randomized run
// scored against a transaction-level model of the stage.
module tb_datareq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i, ready_i, dmem_gnt_i;
    logic [31:0] pc_i, inst_i, r0data_i, r1data_i, result_i;
    logic        ready_o, valid_ro, maerr_ro, dmem_req_o, dmem_we_o;
    logic [31:0] pc_ro, inst_ro, r0data_ro, r1data_ro, result_ro;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_be_o;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] I_ADDI  = 32'h00100093;
    localparam logic [31:0] I_ADDI2 = 32'h00200113;
    localparam logic [31:0] I_SB    = 32'h00208023;
    localparam logic [31:0] I_LW    = 32'h0000A103;
    localparam logic [31:0] I_LH    = 32'h00009103;
    localparam logic [31:0] I_LD3   = 32'h0000B103;

    datareq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .valid_ro     (valid_ro),
        .ready_i      (ready_i),
        .pc_i         (pc_i),
        .inst_i       (inst_i),
        .r0data_i     (r0data_i),
        .r1data_i     (r1data_i),
        .result_i     (result_i),
        .pc_ro        (pc_ro),
        .inst_ro      (inst_ro),
        .r0data_ro    (r0data_ro),
        .r1data_ro    (r1data_ro),
        .result_ro    (result_ro),
        .maerr_ro     (maerr_ro),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_be_o    (dmem_be_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_gnt_i   (dmem_gnt_i)
    );

    always #5 clk = ~clk;

    // Expected outcome of one accepted bundle.
    typedef struct {
        logic [31:0] pc, inst, r0, r1, res;
        logic        maerr, req, we;
        logic [3:0]  be;
        logic [31:0] addr, wdata;
    } exp_t;

    exp_t exp_out_q[$];
    exp_t exp_req_q[$];

    // Reference: derive access size, legality and lane layout arithmetically.
    function automatic exp_t model(input logic [31:0] pc, inst, r0, r1, res);
        exp_t e;
        logic [6:0] opc;
        logic [2:0] f3;
        bit ld, st, legal;
        int nbytes;
        e.pc = pc; e.inst = inst; e.r0 = r0; e.r1 = r1; e.res = res;
        opc = inst[6:0];
        f3  = inst[14:12];
        ld  = (opc == 7'h03);
        st  = (opc == 7'h23);
        legal  = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : st ? (f3 <= 3'd2) : 1'b0;
        nbytes = 1 << f3[1:0];
        e.req   = legal && ((int'(res[1:0]) % nbytes) == 0);
        e.maerr = (ld || st) && !e.req;
        e.we    = e.req && st;
        e.be    = 4'b0;
        e.addr  = 32'h0;
        e.wdata = 32'h0;
        if (e.req) begin
            e.addr = res & 32'hFFFF_FFFC;
            e.be   = 4'((1 << nbytes) - 1) << res[1:0];
            if (st) begin
                if (nbytes == 1)      e.wdata = {24'h0, r1[7:0]} * 32'h0101_0101;
                else if (nbytes == 2) e.wdata = {16'h0, r1[15:0]} * 32'h0001_0001;
                else                  e.wdata = r1;
            end
        end
        return e;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, inst, r0, r1, res);
        valid_i  = v;
        pc_i     = pc;
        inst_i   = inst;
        r0data_i = r0;
        r1data_i = r1;
        result_i = res;
    endtask

    task automatic test_reset();
        checks++;
        if ({valid_ro, maerr_ro, dmem_req_o, dmem_we_o, ready_o} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00001", {valid_ro, maerr_ro, dmem_req_o, dmem_we_o, ready_o});
        end
        checks++;
        if ({pc_ro, inst_ro, r0data_ro, r1data_ro, result_ro, dmem_addr_o, dmem_wdata_o, dmem_be_o} !== '0) begin
            errors++;
            $display("FAIL reset_data: pc=%h inst=%h addr=%h be=%b not all zero", pc_ro, inst_ro, dmem_addr_o, dmem_be_o);
        end
    endtask

    task automatic test_nonmemop();
        ready_i = 1'b1;
        drive(1'b1, 32'h100, I_ADDI, 32'd11, 32'd22, 32'd33);
        cyc();
        checks++;
        if ({valid_ro, ready_o, dmem_req_o, maerr_ro} !== 4'b1100) begin
            errors++;
            $display("FAIL addi_ctrl: got %b want 1100", {valid_ro, ready_o, dmem_req_o, maerr_ro});
        end
        checks++;
        if ({pc_ro, inst_ro, r0data_ro, r1data_ro, result_ro} !== {32'h100, I_ADDI, 32'd11, 32'd22, 32'd33}) begin
            errors++;
            $display("FAIL addi_bundle: pc=%h inst=%h res=%h", pc_ro, inst_ro, result_ro);
        end
        valid_i = 1'b0;
        cyc();
        checks++;
        if ({valid_ro, ready_o, dmem_req_o} !== 3'b010) begin
            errors++;
            $display("FAIL addi_drain: got %b want 010", {valid_ro, ready_o, dmem_req_o});
        end
    endtask

    task automatic test_store_late_grant();
        dmem_gnt_i = 1'b0;
        drive(1'b1, 32'h104, I_SB, 32'h0, 32'h0000_00A5, 32'h1003);
        cyc();
        valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({dmem_req_o, dmem_we_o, ready_o, valid_ro} !== 4'b1100) begin
                errors++;
                $display("FAIL sb_req_ctrl[%0d]: got %b want 1100", i, {dmem_req_o, dmem_we_o, ready_o, valid_ro});
            end
            checks++;
            if ({dmem_addr_o, dmem_be_o, dmem_wdata_o} !== {32'h1000, 4'b1000, 32'hA5A5_A5A5}) begin
                errors++;
                $display("FAIL sb_req_data[%0d]: addr=%h be=%b wdata=%h want 1000/1000/a5a5a5a5", i, dmem_addr_o, dmem_be_o, dmem_wdata_o);
            end
            if (i == 2) dmem_gnt_i = 1'b1;
            cyc();
        end
        dmem_gnt_i = 1'b0;
        checks++;
        if ({dmem_req_o, valid_ro, maerr_ro, pc_ro} !== {3'b010, 32'h104}) begin
            errors++;
            $display("FAIL sb_done: req/valid/maerr=%b pc=%h want 010/104", {dmem_req_o, valid_ro, maerr_ro}, pc_ro);
        end
        cyc();
    endtask

    task automatic test_misaligned();
        ready_i = 1'b1;
        drive(1'b1, 32'h108, I_LW, 32'h0, 32'h0, 32'h2002);
        cyc();
        checks++;
        if ({valid_ro, dmem_req_o, maerr_ro} !== 3'b101) begin
            errors++;
            $display("FAIL lw_misaligned: valid/req/maerr=%b want 101", {valid_ro, dmem_req_o, maerr_ro});
        end
        drive(1'b1, 32'h10C, I_LH, 32'h0, 32'hFFFF_1234, 32'h2002);
        cyc();
        valid_i = 1'b0;
        checks++;
        if ({dmem_req_o, dmem_we_o, valid_ro, ready_o, dmem_be_o, dmem_addr_o, dmem_wdata_o}
            !== {4'b1000, 4'b1100, 32'h2000, 32'h0}) begin
            errors++;
            $display("FAIL lh_req: ctrl=%b be=%b addr=%h wdata=%h want 1000/1100/2000/0",
                     {dmem_req_o, dmem_we_o, valid_ro, ready_o}, dmem_be_o, dmem_addr_o, dmem_wdata_o);
        end
        dmem_gnt_i = 1'b1;
        cyc();
        dmem_gnt_i = 1'b0;
        checks++;
        if ({valid_ro, maerr_ro, pc_ro} !== {2'b10, 32'h10C}) begin
            errors++;
            $display("FAIL lh_done: valid/maerr=%b pc=%h want 10/10c", {valid_ro, maerr_ro}, pc_ro);
        end
        cyc();
    endtask

    task automatic test_bad_funct3();
        ready_i = 1'b1;
        drive(1'b1, 32'h110, I_LD3, 32'h0, 32'h0, 32'h3000);
        cyc();
        valid_i = 1'b0;
        checks++;
        if ({valid_ro, dmem_req_o, maerr_ro} !== 3'b101) begin
            errors++;
            $display("FAIL bad_funct3: valid/req/maerr=%b want 101", {valid_ro, dmem_req_o, maerr_ro});
        end
        cyc();
        checks++;
        if ({valid_ro, dmem_req_o, ready_o} !== 3'b001) begin
            errors++;
            $display("FAIL bad_funct3_drain: got %b want 001", {valid_ro, dmem_req_o, ready_o});
        end
    endtask

    task automatic test_stall();
        ready_i = 1'b1;
        drive(1'b1, 32'h200, I_ADDI, 32'd1, 32'd2, 32'd3);
        cyc();
        ready_i = 1'b0;
        drive(1'b1, 32'h204, I_ADDI2, 32'd4, 32'd5, 32'd6);
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({ready_o, valid_ro, dmem_req_o, pc_ro, inst_ro, result_ro} !== {3'b010, 32'h200, I_ADDI, 32'd3}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: rdy/valid/req=%b pc=%h res=%h want 010/200/3",
                         i, {ready_o, valid_ro, dmem_req_o}, pc_ro, result_ro);
            end
            cyc();
        end
        ready_i = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_ready: got %b want 1", ready_o);
        end
        cyc();
        valid_i = 1'b0;
        checks++;
        if ({valid_ro, pc_ro, result_ro} !== {1'b1, 32'h204, 32'd6}) begin
            errors++;
            $display("FAIL stall_next: valid=%b pc=%h res=%h want 1/204/6", valid_ro, pc_ro, result_ro);
        end
        cyc();
    endtask

    task automatic test_reset_in_req();
        dmem_gnt_i = 1'b0;
        drive(1'b1, 32'h300, I_SB, 32'h0, 32'h5A, 32'h4001);
        cyc();
        valid_i = 1'b0;
        checks++;
        if (dmem_req_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_req_pre: req=%b want 1", dmem_req_o);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({dmem_req_o, valid_ro, ready_o, dmem_we_o, dmem_be_o, dmem_addr_o} !== {4'b0010, 4'b0, 32'h0}) begin
            errors++;
            $display("FAIL rst_async: req/valid/rdy/we=%b be=%b addr=%h want 0010/0/0",
                     {dmem_req_o, valid_ro, ready_o, dmem_we_o}, dmem_be_o, dmem_addr_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        checks++;
        if ({ready_o, valid_ro, dmem_req_o} !== 3'b100) begin
            errors++;
            $display("FAIL rst_after: rdy/valid/req=%b want 100", {ready_o, valid_ro, dmem_req_o});
        end
    endtask

    // Scores one cycle at the falling edge against the transaction queues.
    task automatic monitor();
        exp_t e;
        checks++;
        if (valid_ro) begin
            if (exp_out_q.size() == 0 || exp_req_q.size() != 0) begin
                errors++;
                $display("FAIL rnd_valid_unexpected: out_q=%0d req_q=%0d", exp_out_q.size(), exp_req_q.size());
            end else begin
                e = exp_out_q[0];
                if ({pc_ro, inst_ro, r0data_ro, r1data_ro, result_ro, maerr_ro} !== {e.pc, e.inst, e.r0, e.r1, e.res, e.maerr}) begin
                    errors++;
                    $display("FAIL rnd_bundle: pc=%h inst=%h res=%h maerr=%b want pc=%h inst=%h res=%h maerr=%b",
                             pc_ro, inst_ro, result_ro, maerr_ro, e.pc, e.inst, e.res, e.maerr);
                end
                if (ready_i) void'(exp_out_q.pop_front());
            end
        end else if (exp_out_q.size() != 0 && exp_req_q.size() == 0) begin
            errors++;
            $display("FAIL rnd_not_presented: valid=0 with completed bundle pc=%h", exp_out_q[0].pc);
        end else if (exp_out_q.size() == 0 && ready_o !== 1'b1) begin
            errors++;
            $display("FAIL rnd_idle_ready: ready=%b want 1", ready_o);
        end

        if (dmem_req_o) begin
            checks++;
            if (exp_req_q.size() == 0) begin
                errors++;
                $display("FAIL rnd_req_unexpected: req=1 with no memop pending");
            end else begin
                e = exp_req_q[0];
                if ({dmem_addr_o, dmem_be_o, dmem_wdata_o, dmem_we_o, ready_o} !== {e.addr, e.be, e.wdata, e.we, 1'b0}) begin
                    errors++;
                    $display("FAIL rnd_req_fields: addr=%h be=%b wdata=%h we=%b rdy=%b want %h/%b/%h/%b/0",
                             dmem_addr_o, dmem_be_o, dmem_wdata_o, dmem_we_o, ready_o, e.addr, e.be, e.wdata, e.we);
                end
                if (dmem_gnt_i) void'(exp_req_q.pop_front());
            end
        end

        if (valid_i && ready_o) begin
            checks++;
            if (exp_out_q.size() != 0) begin
                errors++;
                $display("FAIL rnd_overfill: accepted with %0d bundle(s) still held", exp_out_q.size());
            end
            e = model(pc_i, inst_i, r0data_i, r1data_i, result_i);
            exp_out_q.push_back(e);
            if (e.req) exp_req_q.push_back(e);
        end
    endtask

    task automatic test_random();
        logic [31:0] inst, res;
        exp_out_q.delete();
        exp_req_q.delete();
        for (int n = 0; n < 800; n++) begin
            inst = $urandom;
            case ($urandom_range(0, 3))
                0:       inst[6:0] = 7'b0000011;
                1:       inst[6:0] = 7'b0100011;
                2:       inst[6:0] = 7'b0010011;
                default: inst[6:0] = 7'b0110011;
            endcase
            res = $urandom;
            if ($urandom_range(0, 1) == 0) res[1:0] = 2'b00;
            drive(1'($urandom_range(0, 3) != 0), $urandom, inst, $urandom, $urandom, res);
            ready_i    = 1'($urandom_range(0, 9) < 7);
            dmem_gnt_i = 1'($urandom_range(0, 1));
            @(negedge clk);
            monitor();
            cyc();
        end
        valid_i    = 1'b0;
        ready_i    = 1'b1;
        dmem_gnt_i = 1'b1;
        for (int n = 0; n < 20 && exp_out_q.size() != 0; n++) begin
            @(negedge clk);
            monitor();
            cyc();
        end
        dmem_gnt_i = 1'b0;
        checks++;
        if (exp_out_q.size() != 0) begin
            errors++;
            $display("FAIL rnd_drain_timeout: %0d bundle(s) never delivered", exp_out_q.size());
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        ready_i    = 1'b0;
        dmem_gnt_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        test_nonmemop();
        test_store_late_grant();
        test_misaligned();
        test_bad_funct3();
        test_stall();
        test_reset_in_req();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
